uart_cmd_rcv: RTL and testbench

Host-command receiver for the logic analyzer core. Deserializes the host UART line on `RX`, assembles each pair of received bytes into one 16-bit command (high byte first), and presents it to the command processor with a `cmd_rdy` flag. It is the receiving end of the byte stream the host-side command master transmits. Responses go back to the host through the existing `UART_tx`.

---
 rtl/la_comm_pkg.sv | 38 +++
 rtl/uart_rx_core.sv | 130 +++++++++++++
 rtl/uart_cmd_rcv.sv | 118 +++++++++++
 tb/tb_uart_cmd_rcv.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_comm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : la_comm_pkg                                                   |
// | Purpose  : Shared definitions for the logic-analyzer host link: receiver |
// |            and assembler state types, default baud divisor, and the      |
// |            command opcodes the command processor decodes.               |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package la_comm_pkg;

  // Bit-engine states of the serial receiver
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Byte-pair assembler states
  typedef enum logic [0:0] {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_t;

  // 115200 baud from a 100 MHz clock
  localparam int unsigned DEF_BAUD_DIV = 868;

  // Command opcodes carried in cmd[15:8]
  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_WR_REG   = 8'h01;
  localparam logic [7:0] OP_RD_REG   = 8'h02;
  localparam logic [7:0] OP_ARM      = 8'h04;
  localparam logic [7:0] OP_DUMP     = 8'h08;
  localparam logic [7:0] OP_RESET_LA = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_core                                                  |
// | Purpose  : 8N1 UART receiver: 2-flop synchronizer, start-edge detect,    |
// |            down-counting baud timer and bit engine.                      |
// | Ports    : clk, rst          - clock, synchronous active-high reset      |
// |            rx                - asynchronous serial line (idles high)     |
// |            rx_byte[7:0]      - last received byte (valid with byte_rdy)  |
// |            byte_rdy          - one-cycle pulse, good byte received       |
// |            frm_err           - one-cycle pulse, stop bit sampled low     |
// |            rx_busy           - a frame is being received                 |
// |            start_edge        - accepted start edge (engine was idle)     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_rx_core
  import la_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_rdy,
  output logic       frm_err,
  output logic       rx_busy,
  output logic       start_edge
);

  localparam int unsigned     CW       = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0]   CNT_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0]   CNT_FULL = CW'(BAUD_DIV);

  logic          sync1, sync2, line_q;
  rx_state_t     state, state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          fall, expire;
  logic          load_half, load_full, shift_en, byte_done, stop_bad;

  // line_q is the previous synchronized value, kept in every state so a
  // line held low (break) never looks like a fresh edge.
  assign fall       = line_q & ~sync2;
  assign expire     = (baud_cnt == CW'(1));
  assign start_edge = (state == IDLE) & fall;
  assign rx_busy    = (state != IDLE);
  assign rx_byte    = shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          load_half = 1'b1;
        end
      end
      START: begin
        if (expire) begin
          if (sync2) begin
            state_nxt = IDLE;          // glitch, not a real start bit
          end else begin
            state_nxt = DATA;
            load_full = 1'b1;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (expire) begin
          state_nxt = IDLE;
          if (sync2) byte_done = 1'b1;
          else       stop_bad  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      line_q   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      byte_rdy <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      sync1    <= rx;
      sync2    <= sync1;
      line_q   <= sync2;
      byte_rdy <= byte_done;
      frm_err  <= stop_bad;

      if (load_half)            baud_cnt <= CNT_HALF;
      else if (load_full)       baud_cnt <= CNT_FULL;
      else if (baud_cnt != '0)  baud_cnt <= baud_cnt - CW'(1);

      if (load_half)            bit_cnt <= '0;
      else if (shift_en)        bit_cnt <= bit_cnt + 3'd1;

      // LSB arrives first, so shift right
      if (shift_en)             shift <= {sync2, shift[7:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_rcv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_cmd_rcv                                                  |
// | Purpose  : Host-command receiver. Pairs received UART bytes into 16-bit  |
// |            commands (high byte first) and flags them with cmd_rdy.      |
// | Ports    : clk, rst          - clock, synchronous active-high reset      |
// |            RX                - serial line from host (idles high)        |
// |            clr_cmd_rdy       - pulse from command processor, drops flag  |
// |            cmd[15:8]/[7:0]   - {first byte, second byte}                 |
// |            cmd_rdy           - complete command valid on cmd             |
// |            frm_err           - one-cycle pulse on a bad stop bit         |
// |            rx_busy           - receiver is inside a frame                |
// | Options  : UART_CMD_TIMEOUT_EN - abandon a lone high byte after          |
// |            TIMEOUT_BITS bit periods without a following start edge.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_cmd_rcv
  import la_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV     = DEF_BAUD_DIV,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err,
  output logic        rx_busy
);

  if (BAUD_DIV < 16 || BAUD_DIV > 65535 || TIMEOUT_BITS == 0) begin : g_bad_cfg
    $error("uart_cmd_rcv: BAUD_DIV must be 16..65535 and TIMEOUT_BITS nonzero");
  end

  logic       [7:0] rx_byte;
  logic             byte_rdy;
  logic             start_edge;
  logic             tmo_expire;
  asm_state_t       asm_state, asm_nxt;

  uart_rx_core #(
    .BAUD_DIV   (BAUD_DIV)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .rx         (RX),
    .rx_byte    (rx_byte),
    .byte_rdy   (byte_rdy),
    .frm_err    (frm_err),
    .rx_busy    (rx_busy),
    .start_edge (start_edge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_state <= WAIT_HI;
    end else begin
      asm_state <= asm_nxt;
    end
  end

  always_comb begin
    asm_nxt = asm_state;
    if (frm_err || tmo_expire) begin
      asm_nxt = WAIT_HI;
    end else if (byte_rdy) begin
      asm_nxt = (asm_state == WAIT_HI) ? WAIT_LO : WAIT_HI;
    end
  end

  // A start edge while waiting for a high byte means a new command is on
  // its way, so the old one is retired before cmd[15:8] gets overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd     <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      if (byte_rdy && asm_state == WAIT_HI) cmd[15:8] <= rx_byte;
      if (byte_rdy && asm_state == WAIT_LO) cmd[7:0]  <= rx_byte;

      if (byte_rdy && asm_state == WAIT_LO)
        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || (start_edge && asm_state == WAIT_HI))
        cmd_rdy <= 1'b0;
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned TW         = $clog2(TMO_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_run;

  // A start edge in the expiry cycle wins: the low byte is already coming.
  assign tmo_expire = tmo_run & (tmo_cnt == TW'(1)) & ~start_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_run <= 1'b0;
      tmo_cnt <= '0;
    end else if (byte_rdy && asm_state == WAIT_HI) begin
      tmo_run <= 1'b1;
      tmo_cnt <= TW'(TMO_CYCLES);
    end else if (start_edge || tmo_expire) begin
      tmo_run <= 1'b0;
    end else if (tmo_run) begin
      tmo_cnt <= tmo_cnt - TW'(1);
    end
  end
`else
  assign tmo_expire = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rcv.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_cmd_rcv                                               |
// | Purpose  : Self-checking bench for uart_cmd_rcv (BAUD_DIV=16).           |
// |            Byte table with constant expectations, hand sequences for     |
// |            clear, glitch, inter-byte timeout and mid-frame reset, then   |
// |            random bytes against a queue-based pairing model.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_cmd_rcv;

  localparam int N = 16;
  localparam int H = N / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX  = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;
  logic        rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frm_cnt = 0;
  int rise_cyc = -1;
  logic rdy_prev = 1'b0;

  uart_cmd_rcv #(
    .BAUD_DIV     (N),
    .TIMEOUT_BITS (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .frm_err     (frm_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor on the inactive edge
  always @(negedge clk) begin
    if (frm_err === 1'b1) frm_cnt <= frm_cnt + 1;
    if (cmd_rdy === 1'b1 && rdy_prev !== 1'b1) rise_cyc <= cyc;
    rdy_prev <= cmd_rdy;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic v);
    RX = v;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int nb);
    RX = 1'b1;
    repeat (nb * N) @(posedge clk);
    #1;
  endtask

  // k = cycle number of the edge just before the start bit is driven
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, output int k);
    k = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok ? 1'b1 : 1'b0);
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          stop_ok;
    int          gap;
    bit          clr_after;
    logic [15:0] exp_cmd;
    bit          exp_rdy;
    int          exp_frm;
  } vec_t;

  vec_t vecs[9];

  // Random-phase reference model
  logic [7:0]  q[$];
  logic [15:0] m_cmd;
  logic        m_rdy;
  int          m_frm;

  initial begin
    int k;
    logic [7:0] b;
    bit ok;
    int gap;

    vecs[0] = '{8'h48, 1'b1, 0, 1'b0, 16'h4800, 1'b0, 0};
    vecs[1] = '{8'h12, 1'b1, 2, 1'b1, 16'h4812, 1'b1, 0};
    vecs[2] = '{8'h88, 1'b1, 0, 1'b0, 16'h8812, 1'b0, 0};
    vecs[3] = '{8'h00, 1'b1, 2, 1'b0, 16'h8800, 1'b1, 0};
    vecs[4] = '{8'hA5, 1'b0, 2, 1'b0, 16'h8800, 1'b0, 1};
    vecs[5] = '{8'h5A, 1'b1, 2, 1'b0, 16'h5A00, 1'b0, 1};
    vecs[6] = '{8'h01, 1'b1, 2, 1'b0, 16'h5A01, 1'b1, 1};
    vecs[7] = '{8'h01, 1'b1, 0, 1'b0, 16'h0101, 1'b0, 1};
    vecs[8] = '{8'h02, 1'b1, 2, 1'b0, 16'h0102, 1'b1, 1};

    // Reset
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_cmd",     32'(cmd),     32'h0);
    check("reset_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("reset_frm_err", 32'(frm_err), 32'h0);
    check("reset_rx_busy", 32'(rx_busy), 32'h0);
    idle_bits(1);

    // Byte table
    for (int i = 0; i < 9; i++) begin
      send_byte(vecs[i].data, vecs[i].stop_ok, k);
      idle_bits(vecs[i].gap);
      check($sformatf("vec%0d_cmd", i),     32'(cmd),     32'(vecs[i].exp_cmd));
      check($sformatf("vec%0d_cmd_rdy", i), 32'(cmd_rdy), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_frm_cnt", i), 32'(frm_cnt), 32'(vecs[i].exp_frm));
      if (vecs[i].exp_rdy)
        check($sformatf("vec%0d_rdy_latency", i), 32'(rise_cyc), 32'(k + 4 + H + 9 * N));
      if (vecs[i].clr_after) begin
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        check($sformatf("vec%0d_clr_rdy", i), 32'(cmd_rdy), 32'h0);
        check($sformatf("vec%0d_clr_cmd", i), 32'(cmd),     32'(vecs[i].exp_cmd));
      end
    end

    // Short glitch: engine starts, rejects at the START resample
    k = cyc;
    RX = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("glitch_busy_rise", 32'(rx_busy), 32'h1);
    RX = 1'b1;
    repeat (H - 1) @(posedge clk);
    #1;
    check("glitch_busy_hold", 32'(rx_busy), 32'h1);
    @(posedge clk);
    #1;
    check("glitch_busy_drop", 32'(rx_busy), 32'h0);
    idle_bits(3);
    check("glitch_cmd",     32'(cmd),     32'h0102);
    check("glitch_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("glitch_frm_cnt", 32'(frm_cnt), 32'd1);

    // Inter-byte gap longer than the timeout
    send_byte(8'h12, 1'b1, k);
    idle_bits(21);
    send_byte(8'h34, 1'b1, k);
`ifdef UART_CMD_TIMEOUT_EN
    check("tmo_mid_cmd",     32'(cmd),     32'h3402);
    check("tmo_mid_cmd_rdy", 32'(cmd_rdy), 32'h0);
`else
    check("tmo_mid_cmd",     32'(cmd),     32'h1234);
    check("tmo_mid_cmd_rdy", 32'(cmd_rdy), 32'h1);
`endif
    send_byte(8'h56, 1'b1, k);
    idle_bits(2);
`ifdef UART_CMD_TIMEOUT_EN
    check("tmo_end_cmd",     32'(cmd),     32'h3456);
    check("tmo_end_cmd_rdy", 32'(cmd_rdy), 32'h1);
`else
    check("tmo_end_cmd",     32'(cmd),     32'h5634);
    check("tmo_end_cmd_rdy", 32'(cmd_rdy), 32'h0);
`endif
    check("tmo_frm_cnt", 32'(frm_cnt), 32'd1);

    // Reset in the middle of data bit 4 of a second byte
    idle_bits(25);
    send_byte(8'h77, 1'b1, k);
    RX = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    RX = 1'b0;
    repeat (H) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(rx_busy), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_cmd",     32'(cmd),     32'h0);
    check("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("mid_rst_frm_err", 32'(frm_err), 32'h0);
    check("mid_rst_rx_busy", 32'(rx_busy), 32'h0);
    rst = 1'b0;
    idle_bits(2);
    send_byte(8'hFF, 1'b1, k);
    send_byte(8'hFF, 1'b1, k);
    idle_bits(1);
    check("post_rst_cmd",     32'(cmd),     32'hFFFF);
    check("post_rst_cmd_rdy", 32'(cmd_rdy), 32'h1);
    check("post_rst_latency", 32'(rise_cyc), 32'(k + 4 + H + 9 * N));
    check("post_rst_frm_cnt", 32'(frm_cnt), 32'd1);

    // Random bytes against a pairing model
    q.delete();
    m_cmd = 16'hFFFF;
    m_rdy = 1'b1;
    m_frm = 1;
    for (int n = 0; n < 24; n++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 5) != 0);
      gap = ok ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
      send_byte(b, ok, k);
      idle_bits(gap);

      // Any start while no high byte is pending retires the old command
      if (q.size() == 0) m_rdy = 1'b0;
      if (ok) begin
        q.push_back(b);
        if (q.size() == 1) begin
          m_cmd[15:8] = b;
        end else begin
          m_cmd = {q[0], q[1]};
          m_rdy = 1'b1;
          q.delete();
          check($sformatf("rnd%0d_latency", n), 32'(rise_cyc), 32'(k + 4 + H + 9 * N));
        end
      end else begin
        q.delete();
        m_frm++;
      end
      check($sformatf("rnd%0d_cmd", n),     32'(cmd),     32'(m_cmd));
      check($sformatf("rnd%0d_cmd_rdy", n), 32'(cmd_rdy), 32'(m_rdy));
      check($sformatf("rnd%0d_frm_cnt", n), 32'(frm_cnt), 32'(m_frm));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
